layer_cfg_regs: RTL and testbench
=================================

Name: layer_cfg_regs

Overview:
- Runtime layer-configuration register block; successor to the fixed compile-time model constants.
- Software writes shadow registers for image size, kernel size, channel count and stride, then requests a commit.
- The block validates the shadow set against the synthesized hardware limits and computes derived dimensions. It swaps the result into the active set only when the datapath reports idle.
- Sits between the host config bus and the line buffer, systolic-array wrapper and weight/bias fetch logic.

Parameters:
- MAX_LINE_W, 1920, largest legal image width.
- MAX_K_R, 7, largest legal kernel height/width.
- MAX_TILE_W, 64, systolic column count; must be a power of two (used for tile count).
- MAX_CHANNELS, 16, largest legal output-channel count.
- DIM_W, 16, width of dimension registers and cfg_wdata.
- DEF_IMG_W / DEF_IMG_H / DEF_K_R / DEF_K_S / DEF_CH, 28/28/5/5/6, reset values (LeNet conv1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_wr_en  in  1  shadow register write strobe.
- cfg_addr  in  3  register select: 0 IMG_W, 1 IMG_H, 2 K_R, 3 K_S, 4 K_CHANNELS, 5 STRIDE_LOG2; 6–7 reserved.
- cfg_wdata  in  DIM_W  write data.
- cfg_commit  in  1  single-cycle commit request.
- layer_busy  in  1  datapath is mid-layer; active set must not change.
- cfg_busy  out  1  FSM not in IDLE.
- cfg_wr_drop  out  1  pulse: write or commit ignored.
- cfg_applied  out  1  pulse: active set updated.
- cfg_err  out  1  pulse: commit rejected.
- err_code  out  3  sticky cause of the last rejection.
- act_img_w, act_img_h, act_k_r, act_k_s, act_ch  out  DIM_W  active configuration.
- act_stride_log2  out  2  active stride exponent.
- act_out_w, act_out_h  out  DIM_W  derived output dimensions.
- act_n_tiles  out  DIM_W  ceil(act_out_w / MAX_TILE_W).
- act_kernel_taps  out  2*DIM_W  act_k_r * act_k_s.

Behaviour:
- Reset state:
  - Shadow and active registers load the DEF_* values; stride_log2 = 0.
  - act_out_w = act_out_h = 24, act_n_tiles = 1, act_kernel_taps = 25.
  - err_code = 0; all pulses low; FSM in IDLE.
  - Reset mid-commit aborts the commit and restores defaults.
- FSM states: IDLE -> CHECK -> DERIVE -> WAIT_IDLE -> IDLE.
- IDLE:
  - cfg_wr_en writes the shadow register, taking the low bits for STRIDE_LOG2.
  - Writes to addresses 6–7 are ignored silently.
  - cfg_commit moves to CHECK and clears err_code.
  - A write and a commit in the same cycle: the write lands first and the commit uses the new value.
- CHECK (1 cycle): legality test, first failing rule sets err_code in priority order:
  - 1: img_w = 0, img_w > MAX_LINE_W, or img_h = 0.
  - 2: k_r or k_s = 0 or > MAX_K_R.
  - 3: k_s > img_w or k_r > img_h.
  - 4: ch = 0 or ch > MAX_CHANNELS.
  - 5: stride_log2 > 2.
  - On fail: pulse cfg_err, go to IDLE, active set unchanged.
- DERIVE (1 cycle): registers the derived values.
  - out_w = ((img_w - k_s) >> stride_log2) + 1; out_h is computed the same way from img_h and k_r.
  - n_tiles = (out_w + MAX_TILE_W - 1) >> log2(MAX_TILE_W).
  - taps = k_r * k_s.
- WAIT_IDLE: stays while layer_busy = 1.
  - On the first cycle with layer_busy = 0, all act_* outputs update together on that edge and cfg_applied pulses in the following cycle.
  - Go to IDLE.
- Latency: with layer_busy = 0, a commit sampled at edge N gives new act_* values and cfg_applied high in cycle N+4.
- While cfg_busy = 1:
  - cfg_wr_en and cfg_commit are ignored, and cfg_wr_drop pulses one cycle later.
  - The shadow set stays frozen, so the validated values are what gets applied.
- act_* outputs never change except on an apply or a reset; there are no partial updates.
- Arithmetic is unsigned. The subtraction is safe because CHECK guarantees k <= img.

Optional Feature:
- Macro: LAYER_CFG_READBACK_EN.
- When defined:
  - Adds inputs cfg_rd_en (1) and outputs cfg_rdata (DIM_W) and cfg_rd_valid (1).
  - A read returns the shadow register at cfg_addr one cycle later, with cfg_rd_valid high for one cycle.
  - Address 7 returns a status word {cfg_busy, err_code} zero-extended to DIM_W.
  - Reads are allowed in any FSM state.
- When undefined: none of these ports exist and there is no read logic.

Test Plan:
- Reset release -> act_img_w = 28, act_k_s = 5, act_out_w = 24, act_n_tiles = 1, act_kernel_taps = 25, err_code = 0.
- Write IMG_W = 130, IMG_H = 130, K_R = K_S = 3, STRIDE_LOG2 = 1, then commit with layer_busy = 0 -> cfg_applied at commit+4; act_out_w = act_out_h = 64, act_n_tiles = 1, taps = 9.
- Write IMG_W = 1920, K_S = 7, stride 0, commit -> act_out_w = 1914, act_n_tiles = 30.
- Write K_S = 9 and commit -> cfg_err pulse, err_code = 2, act_* unchanged. Then write K_CHANNELS = 0 with K_S = 5 and commit -> err_code = 4.
- Hold layer_busy = 1 for 20 cycles after a valid commit, writing IMG_W = 50 during the wait -> cfg_wr_drop pulses, no apply until layer_busy falls, and the applied img_w is the pre-commit value.
- Assert rst in WAIT_IDLE -> defaults restored, no cfg_applied. With LAYER_CFG_READBACK_EN, read addr 0 after writing 77 -> cfg_rdata = 77 one cycle later.

Source files
------------

// File: rtl/layer_cfg_regs.sv
// Runtime layer-configuration registers: shadow set -> validate -> derive -> swap into active set when the datapath is idle.
// Optional shadow/status readback port enabled by defining LAYER_CFG_READBACK_EN.
module layer_cfg_regs #(
  parameter int MAX_LINE_W   = 1920,
  parameter int MAX_K_R      = 7,
  parameter int MAX_TILE_W   = 64,
  parameter int MAX_CHANNELS = 16,
  parameter int DIM_W        = 16,
  parameter int DEF_IMG_W    = 28,
  parameter int DEF_IMG_H    = 28,
  parameter int DEF_K_R      = 5,
  parameter int DEF_K_S      = 5,
  parameter int DEF_CH       = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_wr_en,
  input  logic [2:0]         cfg_addr,
  input  logic [DIM_W-1:0]   cfg_wdata,
  input  logic               cfg_commit,
  input  logic               layer_busy,
`ifdef LAYER_CFG_READBACK_EN
  input  logic               cfg_rd_en,
  output logic [DIM_W-1:0]   cfg_rdata,
  output logic               cfg_rd_valid,
`endif
  output logic               cfg_busy,
  output logic               cfg_wr_drop,
  output logic               cfg_applied,
  output logic               cfg_err,
  output logic [2:0]         err_code,
  output logic [DIM_W-1:0]   act_img_w,
  output logic [DIM_W-1:0]   act_img_h,
  output logic [DIM_W-1:0]   act_k_r,
  output logic [DIM_W-1:0]   act_k_s,
  output logic [DIM_W-1:0]   act_ch,
  output logic [1:0]         act_stride_log2,
  output logic [DIM_W-1:0]   act_out_w,
  output logic [DIM_W-1:0]   act_out_h,
  output logic [DIM_W-1:0]   act_n_tiles,
  output logic [2*DIM_W-1:0] act_kernel_taps
);

  localparam int TILE_SHIFT = $clog2(MAX_TILE_W);
  localparam logic [DIM_W-1:0] LINE_LIM = DIM_W'(MAX_LINE_W);
  localparam logic [DIM_W-1:0] K_LIM    = DIM_W'(MAX_K_R);
  localparam logic [DIM_W-1:0] CH_LIM   = DIM_W'(MAX_CHANNELS);
  localparam logic [DIM_W-1:0] DEF_OUT_W   = DIM_W'(DEF_IMG_W - DEF_K_S + 1);
  localparam logic [DIM_W-1:0] DEF_OUT_H   = DIM_W'(DEF_IMG_H - DEF_K_R + 1);
  localparam logic [DIM_W-1:0] DEF_N_TILES =
    DIM_W'((DEF_IMG_W - DEF_K_S + 1 + MAX_TILE_W - 1) >> TILE_SHIFT);
  localparam logic [2*DIM_W-1:0] DEF_TAPS = (2*DIM_W)'(DEF_K_R * DEF_K_S);
  // Index order matches cfg_addr 0..4.
  localparam logic [5*DIM_W-1:0] DEF_PACK = {DIM_W'(DEF_CH), DIM_W'(DEF_K_S), DIM_W'(DEF_K_R),
                                             DIM_W'(DEF_IMG_H), DIM_W'(DEF_IMG_W)};

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DERIVE, S_WAIT_IDLE} state_t;

  state_t state_reg, state_next;
  logic [DIM_W-1:0]   shadow_reg [5];
  logic [1:0]         stride_reg;
  logic [DIM_W-1:0]   act_dim_reg [5];
  logic [1:0]         act_stride_reg;
  logic [DIM_W-1:0]   der_out_w_reg, der_out_h_reg, der_n_tiles_reg;
  logic [2*DIM_W-1:0] der_taps_reg;
  logic [DIM_W-1:0]   out_w_calc, out_h_calc, n_tiles_calc;
  logic [2*DIM_W-1:0] taps_calc;
  logic [2:0]         check_code;
  logic               wr_ok, apply_now;
  logic               wr_drop_reg, applied_reg, err_reg;
  logic [2:0]         err_code_reg;

  assign cfg_busy  = (state_reg != S_IDLE);
  assign wr_ok     = cfg_wr_en && !cfg_busy;
  assign apply_now = (state_reg == S_WAIT_IDLE) && !layer_busy;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (cfg_commit) state_next = S_CHECK;
      S_CHECK:     state_next = (check_code != 3'd0) ? S_IDLE : S_DERIVE;
      S_DERIVE:    state_next = S_WAIT_IDLE;
      S_WAIT_IDLE: if (!layer_busy) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Shadow and active dimension registers share one slot layout.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_dim
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_reg[gi]  <= DEF_PACK[gi*DIM_W +: DIM_W];
          act_dim_reg[gi] <= DEF_PACK[gi*DIM_W +: DIM_W];
        end else begin
          if (wr_ok && cfg_addr == 3'(gi)) shadow_reg[gi] <= cfg_wdata;
          if (apply_now) act_dim_reg[gi] <= shadow_reg[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      stride_reg     <= 2'd0;
      act_stride_reg <= 2'd0;
    end else begin
      if (wr_ok && cfg_addr == 3'd5) stride_reg <= cfg_wdata[1:0];
      if (apply_now) act_stride_reg <= stride_reg;
    end
  end

  // First failing rule wins.
  always_comb begin
    check_code = 3'd0;
    if (shadow_reg[0] == '0 || shadow_reg[0] > LINE_LIM || shadow_reg[1] == '0)
      check_code = 3'd1;
    else if (shadow_reg[2] == '0 || shadow_reg[3] == '0 ||
             shadow_reg[2] > K_LIM || shadow_reg[3] > K_LIM)
      check_code = 3'd2;
    else if (shadow_reg[3] > shadow_reg[0] || shadow_reg[2] > shadow_reg[1])
      check_code = 3'd3;
    else if (shadow_reg[4] == '0 || shadow_reg[4] > CH_LIM)
      check_code = 3'd4;
    else if (stride_reg == 2'd3)
      check_code = 3'd5;
  end

  // Subtractions cannot underflow once CHECK has passed.
  assign out_w_calc   = ((shadow_reg[0] - shadow_reg[3]) >> stride_reg) + DIM_W'(1);
  assign out_h_calc   = ((shadow_reg[1] - shadow_reg[2]) >> stride_reg) + DIM_W'(1);
  assign n_tiles_calc = DIM_W'(({1'b0, out_w_calc} + (DIM_W+1)'(MAX_TILE_W - 1)) >> TILE_SHIFT);
  assign taps_calc    = {{DIM_W{1'b0}}, shadow_reg[2]} * {{DIM_W{1'b0}}, shadow_reg[3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      der_out_w_reg   <= DEF_OUT_W;
      der_out_h_reg   <= DEF_OUT_H;
      der_n_tiles_reg <= DEF_N_TILES;
      der_taps_reg    <= DEF_TAPS;
      act_out_w       <= DEF_OUT_W;
      act_out_h       <= DEF_OUT_H;
      act_n_tiles     <= DEF_N_TILES;
      act_kernel_taps <= DEF_TAPS;
    end else begin
      if (state_reg == S_DERIVE) begin
        der_out_w_reg   <= out_w_calc;
        der_out_h_reg   <= out_h_calc;
        der_n_tiles_reg <= n_tiles_calc;
        der_taps_reg    <= taps_calc;
      end
      if (apply_now) begin
        act_out_w       <= der_out_w_reg;
        act_out_h       <= der_out_h_reg;
        act_n_tiles     <= der_n_tiles_reg;
        act_kernel_taps <= der_taps_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_drop_reg  <= 1'b0;
      applied_reg  <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= 3'd0;
    end else begin
      wr_drop_reg <= cfg_busy && (cfg_wr_en || cfg_commit);
      applied_reg <= apply_now;
      err_reg     <= (state_reg == S_CHECK) && (check_code != 3'd0);
      if (state_reg == S_IDLE && cfg_commit)
        err_code_reg <= 3'd0;
      else if (state_reg == S_CHECK && check_code != 3'd0)
        err_code_reg <= check_code;
    end
  end

`ifdef LAYER_CFG_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rd_valid <= 1'b0;
      cfg_rdata    <= '0;
    end else begin
      cfg_rd_valid <= cfg_rd_en;
      if (cfg_rd_en) begin
        case (cfg_addr)
          3'd0, 3'd1, 3'd2, 3'd3, 3'd4: cfg_rdata <= shadow_reg[cfg_addr];
          3'd5:    cfg_rdata <= DIM_W'(stride_reg);
          3'd7:    cfg_rdata <= DIM_W'({cfg_busy, err_code_reg});
          default: cfg_rdata <= '0;
        endcase
      end
    end
  end
`endif

  assign cfg_wr_drop     = wr_drop_reg;
  assign cfg_applied     = applied_reg;
  assign cfg_err         = err_reg;
  assign err_code        = err_code_reg;
  assign act_img_w       = act_dim_reg[0];
  assign act_img_h       = act_dim_reg[1];
  assign act_k_r         = act_dim_reg[2];
  assign act_k_s         = act_dim_reg[3];
  assign act_ch          = act_dim_reg[4];
  assign act_stride_log2 = act_stride_reg;

endmodule

// File: tb/tb_layer_cfg_regs.sv
// Bench for layer_cfg_regs: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural model of the register set.
module tb_layer_cfg_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr_en = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [15:0] cfg_wdata = 16'd0;
  logic        cfg_commit = 1'b0;
  logic        layer_busy = 1'b0;
  logic        cfg_rd_en = 1'b0;
  logic        cfg_busy, cfg_wr_drop, cfg_applied, cfg_err;
  logic [2:0]  err_code;
  logic [15:0] act_img_w, act_img_h, act_k_r, act_k_s, act_ch;
  logic [1:0]  act_stride_log2;
  logic [15:0] act_out_w, act_out_h, act_n_tiles;
  logic [31:0] act_kernel_taps;
`ifdef LAYER_CFG_READBACK_EN
  logic [15:0] cfg_rdata;
  logic        cfg_rd_valid;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  layer_cfg_regs dut (
    .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .layer_busy(layer_busy),
`ifdef LAYER_CFG_READBACK_EN
    .cfg_rd_en(cfg_rd_en), .cfg_rdata(cfg_rdata), .cfg_rd_valid(cfg_rd_valid),
`endif
    .cfg_busy(cfg_busy), .cfg_wr_drop(cfg_wr_drop), .cfg_applied(cfg_applied),
    .cfg_err(cfg_err), .err_code(err_code), .act_img_w(act_img_w),
    .act_img_h(act_img_h), .act_k_r(act_k_r), .act_k_s(act_k_s), .act_ch(act_ch),
    .act_stride_log2(act_stride_log2), .act_out_w(act_out_w), .act_out_h(act_out_h),
    .act_n_tiles(act_n_tiles), .act_kernel_taps(act_kernel_taps)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_sh: 0 img_w, 1 img_h, 2 k_r, 3 k_s, 4 ch, 5 stride_log2.
  int m_sh[6];
  int m_act[6];
  int m_out_w, m_out_h, m_tiles, m_taps;
  int m_phase;        // commit steps remaining bookkeeping: 0 idle, 1 validate, 2 derive, 3 waiting
  bit m_drop, m_applied, m_err, m_rd_valid, started;
  int m_err_code, m_rdata, m_code;

  function automatic int rule_code();
    if (m_sh[0] == 0 || m_sh[0] > 1920 || m_sh[1] == 0) return 1;
    if (m_sh[2] == 0 || m_sh[3] == 0 || m_sh[2] > 7 || m_sh[3] > 7) return 2;
    if (m_sh[3] > m_sh[0] || m_sh[2] > m_sh[1]) return 3;
    if (m_sh[4] == 0 || m_sh[4] > 16) return 4;
    if (m_sh[5] > 2) return 5;
    return 0;
  endfunction

  task automatic model_apply();
    for (int i = 0; i < 6; i++) m_act[i] = m_sh[i];
    m_out_w = (m_sh[0] - m_sh[3]) / (1 << m_sh[5]) + 1;
    m_out_h = (m_sh[1] - m_sh[2]) / (1 << m_sh[5]) + 1;
    m_tiles = (m_out_w + 63) / 64;
    m_taps  = m_sh[2] * m_sh[3];
  endtask

  task automatic model_reset();
    m_sh = '{28, 28, 5, 5, 6, 0};
    model_apply();
    m_phase = 0; m_drop = 0; m_applied = 0; m_err = 0; m_err_code = 0;
    m_rd_valid = 0; m_rdata = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      started = 1;
      model_reset();
    end else begin
      m_rd_valid = cfg_rd_en;
      if (cfg_rd_en)
        m_rdata = (cfg_addr == 3'd7) ? (((m_phase != 0) ? 8 : 0) + m_err_code) :
                  (cfg_addr == 3'd6) ? 0 : m_sh[cfg_addr];
      m_drop = (m_phase != 0) && (cfg_wr_en || cfg_commit);
      m_applied = 0;
      m_err = 0;
      case (m_phase)
        0: begin
          if (cfg_wr_en && cfg_addr < 3'd6)
            m_sh[cfg_addr] = (cfg_addr == 3'd5) ? int'(cfg_wdata % 4) : int'(cfg_wdata);
          if (cfg_commit) begin
            m_err_code = 0;
            m_phase = 1;
          end
        end
        1: begin
          m_code = rule_code();
          if (m_code != 0) begin
            m_err_code = m_code;
            m_err = 1;
            m_phase = 0;
          end else m_phase = 2;
        end
        2: m_phase = 3;
        default: if (!layer_busy) begin
          model_apply();
          m_applied = 1;
          m_phase = 0;
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("busy", cfg_busy, m_phase != 0);
      chk("wr_drop", cfg_wr_drop, m_drop);
      chk("applied", cfg_applied, m_applied);
      chk("err", cfg_err, m_err);
      chk("err_code", err_code, m_err_code);
      chk("act_img_w", act_img_w, m_act[0]);
      chk("act_img_h", act_img_h, m_act[1]);
      chk("act_k_r", act_k_r, m_act[2]);
      chk("act_k_s", act_k_s, m_act[3]);
      chk("act_ch", act_ch, m_act[4]);
      chk("act_stride", act_stride_log2, m_act[5]);
      chk("act_out_w", act_out_w, m_out_w);
      chk("act_out_h", act_out_h, m_out_h);
      chk("act_n_tiles", act_n_tiles, m_tiles);
      chk("act_taps", act_kernel_taps, m_taps);
`ifdef LAYER_CFG_READBACK_EN
      chk("rd_valid", cfg_rd_valid, m_rd_valid);
      if (m_rd_valid) chk("rdata", cfg_rdata, m_rdata);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input int a, input int d);
    cfg_wr_en = 1'b1; cfg_addr = 3'(a); cfg_wdata = 16'(d);
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  // Commit with layer_busy low; apply pulse expected exactly at commit+4.
  task automatic commit_apply(input string tag);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_applied_early"}, cfg_applied, 0);
    @(negedge clk);
    chk({tag, "_applied_n4"}, cfg_applied, 1);
  endtask

  task automatic commit_reject();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    @(negedge clk);
    chk("reject_pulse", cfg_err, 1);
  endtask

  function automatic logic [15:0] rand_data(input logic [2:0] a);
    int r;
    case (a)
      3'd0, 3'd1: begin
        r = $urandom_range(0, 9);
        if (r == 0) return 16'd0;
        if (r == 1) return 16'($urandom_range(1900, 1930));
        return 16'($urandom_range(1, 60));
      end
      3'd2, 3'd3: return 16'($urandom_range(0, 9));
      3'd4:       return 16'($urandom_range(0, 18));
      3'd5:       return 16'($urandom_range(0, 7));
      default:    return 16'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_img_w", act_img_w, 28);
    chk("rst_k_s", act_k_s, 5);
    chk("rst_out_w", act_out_w, 24);
    chk("rst_tiles", act_n_tiles, 1);
    chk("rst_taps", act_kernel_taps, 25);
    chk("rst_err_code", err_code, 0);

    wr(0, 130); wr(1, 130); wr(2, 3); wr(3, 3); wr(5, 1);
    commit_apply("s130");
    chk("s130_out_w", act_out_w, 64);
    chk("s130_out_h", act_out_h, 64);
    chk("s130_tiles", act_n_tiles, 1);
    chk("s130_taps", act_kernel_taps, 9);

    wr(0, 1920); wr(3, 7); wr(5, 0);
    commit_apply("s1920");
    chk("s1920_out_w", act_out_w, 1914);
    chk("s1920_tiles", act_n_tiles, 30);
    chk("s1920_out_h", act_out_h, 128);

    wr(3, 9);
    commit_reject();
    chk("ks9_code", err_code, 2);
    chk("ks9_keep_out_w", act_out_w, 1914);
    wr(3, 5); wr(4, 0);
    commit_reject();
    chk("ch0_code", err_code, 4);
    wr(4, 6);

    // Commit while the datapath is busy; a write during the wait must be dropped.
    wr(0, 200);
    layer_busy = 1'b1;
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    cfg_wr_en = 1'b1; cfg_addr = 3'd0; cfg_wdata = 16'd50;
    @(negedge clk);
    cfg_wr_en = 1'b0;
    chk("busy_drop", cfg_wr_drop, 1);
    repeat (18) @(negedge clk);
    chk("busy_hold_img_w", act_img_w, 1920);
    chk("busy_hold_busy", cfg_busy, 1);
    layer_busy = 1'b0;
    n = 0;
    while (!cfg_applied && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("busy_apply_seen", cfg_applied, 1);
    chk("busy_img_w", act_img_w, 200);
    chk("busy_tiles", act_n_tiles, 4);

    // Reset while waiting to apply.
    wr(0, 100);
    layer_busy = 1'b1;
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    layer_busy = 1'b0;
    chk("rstw_img_w", act_img_w, 28);
    chk("rstw_out_w", act_out_w, 24);
    chk("rstw_busy", cfg_busy, 0);
    repeat (3) @(negedge clk);
    chk("rstw_no_apply", cfg_applied, 0);

`ifdef LAYER_CFG_READBACK_EN
    wr(0, 77);
    cfg_rd_en = 1'b1; cfg_addr = 3'd0;
    @(negedge clk);
    cfg_rd_en = 1'b0;
    chk("rb_valid", cfg_rd_valid, 1);
    chk("rb_data", cfg_rdata, 77);
`endif

    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      cfg_wr_en  = ($urandom_range(0, 2) == 0);
      cfg_addr   = 3'($urandom_range(0, 7));
      cfg_wdata  = rand_data(cfg_addr);
      cfg_commit = ($urandom_range(0, 5) == 0);
      layer_busy = ($urandom_range(0, 3) == 0);
      cfg_rd_en  = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    rst = 1'b0; cfg_wr_en = 1'b0; cfg_commit = 1'b0; layer_busy = 1'b0; cfg_rd_en = 1'b0;
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
